// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtract controller.
//   state_t    : controller FSM encoding (IDLE/RUN/DONE)
//   WIDTH_MIN/WIDTH_MAX : legal operand width range
//   cnt_width  : bit-counter width for a given operand width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    // Counter only needs to reach WIDTH-1; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, bout = borrow out.
//   a, b, bin : operand bits and borrow in
//   diff      : difference bit
//   bout      : borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    // Borrow when b exceeds a, or when they are equal and a borrow arrives.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtract controller: diff = a - b - bin, LSB first, one bit per
// cycle through a single shared full_subtractor cell.
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  : operand handshake; a, b, bin sampled on accept
//   out_valid / out_ready: result handshake; diff, bout held until accepted
//   busy                 : high while an operation is in RUN or DONE
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int unsigned     CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_subtractor_ctrl: WIDTH out of range");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic             r_brw;
    logic [CNT_W-1:0] r_cnt;

    logic             w_d_bit;
    logic             w_bout;

    full_subtractor u_full_subtractor (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_brw),
        .diff (w_d_bit),
        .bout (w_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_res_sh  <= '0;
            r_brw     <= 1'b0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_brw    <= bin;
                        r_cnt    <= '0;
                        r_state  <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_res_sh <= {w_d_bit, r_res_sh[WIDTH-1:1]};
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_brw    <= w_bout;
                    // Counter parks at the last index instead of wrapping.
                    if (r_cnt == CNT_LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the sink.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        diff      <= r_res_sh;
                        bout      <= r_brw;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and randomised checks of serial_subtractor_ctrl at WIDTH=8.
module tb_serial_subtractor_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor_ctrl #(
        .WIDTH (WIDTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid; returns cycles elapsed since the accept edge (0 on timeout).
    task automatic wait_valid(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    // Full transaction: accept, wait for result, stall `stall` cycles, complete handshake.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                          input int stall, input bit check_lat);
        logic [8:0] exp_full;
        logic [7:0] hold_diff;
        logic       hold_bout;
        int         cyc;
        exp_full = {1'b0, ta} - {1'b0, tb_} - {8'd0, tbin};
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a         = ta;
        b         = tb_;
        bin       = tbin;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb_;
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_valid(cyc);
        if (cyc == 0) return;
        if (check_lat) check("latency", 32'(cyc), 32'(WIDTH + 1));
        check("diff", 32'(diff), 32'(exp_full[7:0]));
        check("bout", 32'(bout), 32'(exp_full[8]));
        hold_diff = diff;
        hold_bout = bout;
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_diff", 32'(diff), 32'(hold_diff));
            check("stall_bout", 32'(bout), 32'(hold_bout));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        check("post_hs_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        tick();

        // 1. Basic subtract with latency.
        run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b1);
        tick();
        // 2. Borrow cases.
        run_op(8'h00, 8'h01, 1'b0, 0, 1'b1);
        tick();
        run_op(8'h10, 8'h10, 1'b1, 0, 1'b1);
        tick();
        // 3. Backpressure.
        run_op(8'hC3, 8'h5A, 1'b1, 5, 1'b1);
        tick();

        // 4. in_valid held high with new operands during RUN.
        a        = 8'h5A;
        b        = 8'h3C;
        bin      = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        a   = 8'h11;
        b   = 8'h22;
        bin = 1'b1;
        check("hold_in_ready_run", 32'(in_ready), 32'd0);
        wait_valid(cyc);
        check("hold_latency", 32'(cyc), 32'(WIDTH + 1));
        check("hold_first_diff", 32'(diff), 32'h1E);
        check("hold_first_bout", 32'(bout), 32'd0);
        tick();
        check("hold_idle_in_ready", 32'(in_ready), 32'd1);
        check("hold_idle_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("hold_second_accept", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_valid(cyc);
        check("hold_second_diff", 32'(diff), 32'hEE);
        check("hold_second_bout", 32'(bout), 32'd1);
        tick();
        tick();

        // 5. Reset in the middle of RUN.
        a        = 8'h5A;
        b        = 8'h3C;
        bin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_bout", 32'(bout), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midrst_no_result", 32'(out_valid), 32'd0);
        end
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b1);
        tick();

        // 6. Random operands with random stalls.
        for (int i = 0; i < 1000; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
            if ($urandom_range(0, 1) == 1) tick();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
